mem_line_initiator: RTL and testbench
=====================================

// Module: mem_line_initiator
// PURPOSE
//  Initiator side of the strobe/rw/ready memory handshake. Accepts one request
//  from the cache controller: a line fill (read of LINE_WORDS words) or a
//  single-word write-through. Drives strobe, rw, address and data to the
//  physical memory, waits for each ready pulse and streams fill words back.
//  A watchdog aborts any access that receives no ready within TIMEOUT cycles.
// PARAMETERS
//  LINE_WORDS  4   words per line fill; power of 2, 2..16
//  TIMEOUT     16  max edges strobe is held per word before abort; must be >= 8
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  clr         in   1   synchronous active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block idle, can accept; equals (state==IDLE)
//  req_write   in   1   1 = single-word write, 0 = line fill
//  req_addr    in   32  byte address
//  req_wdata   in   32  write data
//  fill_valid  out  1   one-cycle pulse: fill_data/fill_idx valid
//  fill_data   out  32  returned word
//  fill_idx    out  log2(LINE_WORDS)  word index within line
//  done        out  1   one-cycle pulse: request finished
//  err         out  1   one-cycle pulse with done: request aborted by timeout
//  mem_a       out  32  memory address
//  mem_din     out  32  write data to memory
//  mem_dout    in   32  read data from memory, valid only while mem_ready=1
//  mem_strobe  out  1   access request
//  mem_rw      out  1   1 = write, 0 = read
//  mem_ready   in   1   one-cycle completion pulse from memory
// BEHAVIOUR
//  Reset (clr=1 at posedge): state IDLE. mem_strobe, mem_rw, fill_valid, done
//   and err are 0; mem_a, mem_din, fill_data and fill_idx are 0; word and
//   wait counters are 0. clr has priority over every other event.
//  States: IDLE -> ACCESS -> GAP -> ACCESS ... -> IDLE. All outputs registered.
//  IDLE: req_ready=1. On req_valid, go to ACCESS and set mem_strobe=1.
//   Read: mem_a = line base (req_addr with the low log2(LINE_WORDS)+2 bits
//   zeroed), mem_rw=0. Write: mem_a = {req_addr[31:2],2'b00}, mem_din =
//   req_wdata, mem_rw=1.
//  ACCESS: mem_strobe=1; mem_a, mem_din and mem_rw are held stable.
//   wait_cnt increments on each edge.
//   On the edge that samples mem_ready=1:
//   - Capture mem_dout into fill_data.
//   - Read: fill_valid=1 and fill_idx=word_cnt for one cycle.
//   - Drop mem_strobe, clear wait_cnt.
//   - If this is the last word (or a write), done=1 for one cycle; go to IDLE.
//   - Otherwise go to GAP.
//  GAP: exactly one cycle with strobe=0 so the responder counter clears. Then
//   word_cnt++, mem_a += 4, strobe=1, back to ACCESS.
//  Fill order: word 0..LINE_WORDS-1, ascending. No wrap, no critical-word-first.
//  Timeout: in ACCESS, an edge with wait_cnt==TIMEOUT-1 and mem_ready=0
//   produces strobe=0, done=1, err=1 (one cycle) and state IDLE. The remaining
//   words are not fetched.
//  Same edge has mem_ready=1 and the timeout condition: ready wins, no err.
//  mem_ready outside ACCESS is ignored.
//  A fill is committed only if done=1 and err=0. Consumers discard earlier
//   fill_valid words when err is set or when clr hits mid-request.
//  clr mid-request: IDLE at the next edge, strobe=0, no done or err pulse.
//  Latency with the standard responder (ready 6 edges after strobe rises):
//   one word is sampled 7 edges after acceptance; each further word adds 8.
// TESTING
//  1) Read, req_addr=0x2000_0014, LINE_WORDS=4, 6-cycle responder ->
//     mem_a = 0x2000_0010/14/18/1C; fill_idx 0..3 with matching data;
//     done 31 edges after the accept edge; err=0.
//  2) Write, addr 0x1000_0008, wdata 0xDEADBEEF -> mem_rw=1 held;
//     mem_din=0xDEADBEEF; done 7 edges after accept; no fill_valid; readback = 0xDEADBEEF.
//  3) mem_ready tied 0 -> strobe dropped after 16 strobe edges;
//     done=err=1 for one cycle; req_ready=1 next cycle.
//  4) clr asserted during word 2 of a fill -> IDLE next edge, strobe=0,
//     no done; a new request is accepted normally.
//  5) Ready and timeout on the same edge (responder delay = TIMEOUT-1) -> word accepted, err=0.
//  6) Back-to-back: req_valid held high across two requests -> second accepted
//     the cycle after done; GAP strobe-low cycle present between words.

Source files
------------

// File: rtl/mem_line_initiator_if.sv
// rtl/mem_line_initiator_if.sv - strobe/rw/ready memory bus between initiator and physical memory
interface mem_line_initiator_if;
  logic [31:0] mem_a;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_strobe;
  logic        mem_rw;
  logic        mem_ready;

  modport master (
    output mem_a, mem_din, mem_strobe, mem_rw,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_a, mem_din, mem_strobe, mem_rw,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/mem_line_initiator.sv
// rtl/mem_line_initiator.sv - line-fill / write-through initiator with per-word ready watchdog
module mem_line_initiator #(
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          fill_valid,
  output logic [31:0]                   fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          done,
  output logic                          err,
  mem_line_initiator_if.master          mem
);

  localparam int              IDXW      = $clog2(LINE_WORDS);
  localparam int              WCW       = $clog2(TIMEOUT);
  localparam logic [31:0]     LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [IDXW-1:0] LAST_WORD = IDXW'(LINE_WORDS - 1);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;

  state_t          state;
  logic [IDXW-1:0] word_cnt;
  logic [WCW-1:0]  wait_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      word_cnt       <= '0;
      wait_cnt       <= '0;
      fill_valid     <= 1'b0;
      fill_data      <= '0;
      fill_idx       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem.mem_a      <= '0;
      mem.mem_din    <= '0;
      mem.mem_strobe <= 1'b0;
      mem.mem_rw     <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state          <= ACCESS;
            req_ready      <= 1'b0;
            word_cnt       <= '0;
            wait_cnt       <= '0;
            mem.mem_strobe <= 1'b1;
            mem.mem_rw     <= req_write;
            if (req_write) begin
              mem.mem_a   <= req_addr & 32'hFFFF_FFFC;
              mem.mem_din <= req_wdata;
            end else begin
              mem.mem_a <= req_addr & LINE_MASK;
            end
          end
        end
        ACCESS: begin
          // ready beats the watchdog when both land on the same edge
          if (mem.mem_ready) begin
            fill_data      <= mem.mem_dout;
            wait_cnt       <= '0;
            mem.mem_strobe <= 1'b0;
            if (!mem.mem_rw) begin
              fill_valid <= 1'b1;
              fill_idx   <= word_cnt;
            end
            if (mem.mem_rw || word_cnt == LAST_WORD) begin
              done      <= 1'b1;
              state     <= IDLE;
              req_ready <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            mem.mem_strobe <= 1'b0;
            wait_cnt       <= '0;
            done           <= 1'b1;
            err            <= 1'b1;
            state          <= IDLE;
            req_ready      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          // one strobe-low cycle lets the responder clear its delay counter
          word_cnt       <= word_cnt + 1'b1;
          mem.mem_a      <= mem.mem_a + 32'd4;
          mem.mem_strobe <= 1'b1;
          state          <= ACCESS;
        end
        default: begin
          state          <= IDLE;
          req_ready      <= 1'b1;
          mem.mem_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_initiator.sv
// tb/tb_mem_line_initiator.sv - randomized self-checking bench for mem_line_initiator
module tb_mem_line_initiator;
  localparam int LW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr, req_wdata;
  logic          fill_valid, done, err;
  logic [31:0]   fill_data;
  logic [1:0]    fill_idx;

  int vectors     = 0;
  int miscompares = 0;

  mem_line_initiator_if bus ();

  mem_line_initiator #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_idx   (fill_idx),
    .done       (done),
    .err        (err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  // responder: ready resp_delay strobe-high edges after strobe rises; never for word resp_stall
  int          resp_delay = 6;
  int          resp_stall = LW;
  int          resp_cnt   = 0;
  int          resp_words = 0;
  logic [31:0] resp_mem [0:255];
  bit          resp_written [0:255];

  always @(posedge clk) begin
    if (req_ready) resp_words <= 0;
    if (!bus.mem_strobe || clr) begin
      resp_cnt      <= 0;
      bus.mem_ready <= 1'b0;
    end else if (bus.mem_ready) begin
      bus.mem_ready <= 1'b0;
      resp_words    <= resp_words + 1;
      if (bus.mem_rw) begin
        resp_mem[bus.mem_a[9:2]]     <= bus.mem_din;
        resp_written[bus.mem_a[9:2]] <= 1'b1;
      end
    end else if (resp_words != resp_stall) begin
      resp_cnt <= resp_cnt + 1;
      if (resp_cnt + 1 == resp_delay) begin
        bus.mem_ready <= 1'b1;
        bus.mem_dout  <= resp_written[bus.mem_a[9:2]] ? resp_mem[bus.mem_a[9:2]]
                                                      : init_word(int'(bus.mem_a[9:2]));
      end
    end
  end

  logic [31:0] ref_mem [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int d, input int stall, input bit b2b);
    int          n, words_ok, exp_lat, n_addr, cycles, low_run, hold_bad, stray, guard;
    bit          timed_out, prev_strobe, got_done, got_err;
    logic [31:0] base, wa;
    logic [31:0] got_addr[$];
    int          gaps[$];
    logic [31:0] fdata[$];
    int          fidx[$];

    n         = wr ? 1 : LW;
    base      = wr ? (addr & 32'hFFFF_FFFC) : (addr & ~32'(LW * 4 - 1));
    timed_out = stall < n;
    words_ok  = timed_out ? stall : n;
    exp_lat   = timed_out ? words_ok * (d + 2) + TO : n * (d + 2) - 1;
    n_addr    = timed_out ? words_ok + 1 : n;

    resp_delay = d;
    resp_stall = stall;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 200), 32'd1);

    cycles = -1; prev_strobe = 0; low_run = 0; hold_bad = 0; stray = 0;
    got_done = 0; got_err = 0;
    while (!got_done && cycles < 600) begin
      @(negedge clk);
      cycles++;
      if (cycles == 0) begin
        check("strobe_on_accept", 32'(bus.mem_strobe), 32'd1);
        check("busy_after_accept", 32'(req_ready), 32'd0);
        if (!b2b) req_valid = 1'b0;
      end
      if (bus.mem_strobe) begin
        if (!prev_strobe) begin
          if (got_addr.size() > 0) gaps.push_back(low_run);
          got_addr.push_back(bus.mem_a);
        end
        if (bus.mem_rw !== wr || (wr && bus.mem_din !== wd)) hold_bad++;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_strobe = bus.mem_strobe;
      if (fill_valid) begin
        fidx.push_back(int'(fill_idx));
        fdata.push_back(fill_data);
      end
      if (err && !done) stray++;
      if (done) begin
        got_done = 1;
        got_err  = err;
        check("strobe_at_done", 32'(bus.mem_strobe), 32'd0);
      end
    end

    check("done_seen", 32'(got_done), 32'd1);
    check("latency", cycles, exp_lat);
    check("err", 32'(got_err), 32'(timed_out));
    check("fill_count", fdata.size(), wr ? 0 : words_ok);
    for (int i = 0; i < fdata.size() && i < words_ok; i++) begin
      wa = base + 32'(4 * i);
      check("fill_idx", fidx[i], i);
      check("fill_data", fdata[i], ref_mem[wa[9:2]]);
    end
    check("addr_count", got_addr.size(), n_addr);
    for (int i = 0; i < got_addr.size(); i++)
      check("mem_a", got_addr[i], base + 32'(4 * i));
    foreach (gaps[i]) check("gap_len", gaps[i], 1);
    check("rw_din_hold", hold_bad, 0);
    check("err_without_done", stray, 0);

    if (wr && !timed_out) ref_mem[base[9:2]] = wd;
    if (!b2b) begin
      @(negedge clk);
      check("done_pulse_width", 32'(done), 32'd0);
      check("ready_after_done", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic clr_mid_fill();
    int guard, noisy;
    resp_delay = 6;
    resp_stall = LW;
    req_write  = 1'b0;
    req_addr   = $urandom;
    req_valid  = 1'b1;
    guard = 0;
    while (!(fill_valid && fill_idx == 2'd1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    check("clr_reach_word1", 32'(guard < 200), 32'd1);
    guard = 0;
    while (!bus.mem_strobe && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("clr_word2_strobe", 32'(bus.mem_strobe), 32'd1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_strobe", 32'(bus.mem_strobe), 32'd0);
    check("clr_req_ready", 32'(req_ready), 32'd1);
    check("clr_done", 32'(done), 32'd0);
    check("clr_fill_valid", 32'(fill_valid), 32'd0);
    check("clr_mem_a", bus.mem_a, 32'd0);
    clr   = 1'b0;
    noisy = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || err || bus.mem_strobe) noisy++;
    end
    check("clr_quiet", noisy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit          wr, b2b;
    int          d, stall, n;
    logic [31:0] addr;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_strobe", 32'(bus.mem_strobe), 32'd0);
    check("rst_rw", 32'(bus.mem_rw), 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_din", bus.mem_din, 32'd0);
    check("rst_fill_valid", 32'(fill_valid), 32'd0);
    check("rst_fill_data", fill_data, 32'd0);
    check("rst_fill_idx", 32'(fill_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    run_req(0, 32'h2000_0014, 32'h0, 6, LW, 0);
    run_req(1, 32'h1000_0008, 32'hDEAD_BEEF, 6, LW, 0);
    run_req(0, 32'h1000_0000, 32'h0, 6, LW, 0);
    run_req(0, 32'h3000_0040, 32'h0, 6, 0, 0);
    run_req(0, 32'h3000_0080, 32'h0, 5, 2, 0);
    run_req(0, 32'h4000_0000, 32'h0, TO - 1, LW, 0);
    run_req(0, 32'h5000_0010, 32'h0, 6, LW, 1);
    run_req(1, 32'h5000_0024, 32'h1234_5678, 3, LW, 1);
    run_req(0, 32'h5000_0020, 32'h0, 2, LW, 0);
    clr_mid_fill();
    run_req(0, 32'h6000_0030, 32'h0, 6, LW, 0);

    for (int k = 0; k < 30; k++) begin
      wr    = ($urandom_range(0, 3) == 0);
      addr  = $urandom;
      d     = $urandom_range(1, TO - 1);
      n     = wr ? 1 : LW;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : LW;
      b2b   = (k < 29) && ($urandom_range(0, 1) == 1);
      run_req(wr, addr, $urandom, d, stall, b2b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
